comb_checker: RTL
=================

# comb_checker

Self-checking result stage that consumes the four outputs of the 4-input combinational function implementations (structural, dataflow, behavioural, primitive) while the DCBA stimulus sweeps. Each applied vector is held for a settle window, then all four results are compared against a golden truth table. The block keeps sticky pass/fail status, a mismatch count, a first-failure capture and a coverage map, and signals completion once all 16 input vectors have been checked.

## Interface
- TRUTH, 16'h6996: golden truth table; bit i is the expected output for DCBA = i (default is 4-input odd parity).
- SETTLE, 2: cycles to wait after vector capture before sampling results; legal range 1–15.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear of all status; returns FSM to IDLE
- vld  input  1  one-cycle strobe: vec is applied to the implementations this cycle
- vec  input  4  applied vector {D,C,B,A}
- res  input  4  {prim, behavior, dataflow, str}
- busy  output  1  high in SETTLE and CHECK
- done  output  1  high in DONE (all 16 vectors checked)
- err  output  1  sticky; any mismatch since reset/clr
- err_cnt  output  8  count of checked vectors with ≥1 mismatching bit, saturating at 255
- fail_mask  output  4  sticky per-implementation mismatch flags, same bit order as res
- first_vld  output  1  first-failure capture valid
- first_vec  output  4  vec_q of first failing check
- first_res  output  4  res sampled at first failing check
- cover  output  16  bit i set once vector i has been checked
- ovr  output  1  sticky; vld arrived while not IDLE

## Operation
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0; vec_q and settle counter 0.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE, vld=1: vec_q <= vec, cnt <= SETTLE-1, go to SETTLE.
- SETTLE: if cnt==0, go to CHECK; else cnt <= cnt-1.
- CHECK, single cycle: exp = {4{TRUTH[vec_q]}}; miss = res ^ exp.
  - fail_mask |= miss; cover[vec_q] <= 1.
  - If miss != 0: err <= 1; err_cnt <= min(err_cnt+1, 255). If first_vld==0, capture first_vec <= vec_q, first_res <= res, first_vld <= 1.
  - Next state: DONE if (cover | onehot(vec_q)) == 16'hFFFF, else IDLE.
- DONE: hold until clr. vld is ignored and sets ovr.
- vld while in SETTLE, CHECK or DONE: vector dropped, ovr <= 1, no other effect.
- Repeated vectors are legal: each is compared again and counted; cover is unchanged.
- clr has priority over vld in the same cycle. The next edge gives IDLE with all status outputs cleared.
- rst_n assertion mid-SETTLE/CHECK aborts the check immediately; no status update occurs.

## Timing
- vld sampled at edge E0 → SETTLE after E0. CHECK is entered after edge E_SETTLE, and res is sampled at edge E_SETTLE+1.
- Status outputs (err, err_cnt, fail_mask, first_*, cover) update at edge E_SETTLE+1; done rises at the same edge.
- Earliest next accepted vld: sampled at edge E_SETTLE+2. Throughput is 1 vector per SETTLE+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset/idle: hold rst_n low, toggle vld/res → all outputs 0, busy 0; release → remain 0 until first vld.
- Clean sweep: SETTLE=2, vec 0..15 spaced 4 cycles apart, res = {4{parity(vec)}} → after vec 15, at edge E0+3: done=1, cover=16'hFFFF, err=0, err_cnt=0, fail_mask=0.
- Injected faults: same sweep with res[1] inverted at vec 5 and res[3] inverted at vec 9 → err=1, err_cnt=2, fail_mask=4'b1010, first_vld=1, first_vec=5, first_res=4'b0010, done=1.
- Overrun: second vld 1 cycle after the first → ovr=1; only the first vector appears in cover, and err_cnt is unaffected by the dropped one.
- clr/reset mid-operation: clr in SETTLE after 3 checked vectors → next edge IDLE, cover=0, busy=0. Async rst_n pulse mid-cycle in CHECK → outputs 0 before the next clock edge.
- Saturation: 300 checks of vec 0 with res=4'b1111 → err_cnt=255, fail_mask=4'b1111, cover=16'h0001, done=0.

Source files
------------

// File: rtl/comb_checker.sv
`default_nettype none
// ============================================================================
// Module      : comb_checker
// Description : Result stage for the four implementations of a 4-input
//               combinational function. Each strobed DCBA vector is held for
//               a settle window, after which the four results are compared
//               against a golden truth table. Keeps sticky pass/fail status,
//               a saturating mismatch count, a first-failure capture and a
//               per-vector coverage map; flags completion once all 16
//               vectors have been checked at least once.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TRUTH      golden truth table, bit i = expected output for DCBA = i
//   SETTLE     cycles between vector capture and result sampling (1..15)
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of all status, returns to IDLE (beats vld)
//   vld        one-cycle strobe: vec is being applied this cycle
//   vec        applied vector {D,C,B,A}
//   res        implementation results {prim, behavior, dataflow, str}
//   busy       high while settling or checking
//   done       high once all 16 vectors have been checked (held until clr)
//   err        sticky: at least one mismatch seen
//   err_cnt    checks with >=1 mismatching bit, saturates at 255
//   fail_mask  sticky per-implementation mismatch flags (res bit order)
//   first_vld  first-failure capture valid
//   first_vec  vector of the first failing check
//   first_res  results sampled at the first failing check
//   cover_map  bit i set once vector i has been checked ("cover" itself is
//              a reserved word in SystemVerilog)
//   ovr        sticky: vld arrived while not IDLE (vector dropped)
// ============================================================================
module comb_checker #(
    parameter logic [15:0] TRUTH  = 16'h6996,
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        vld,
    input  logic [3:0]  vec,
    input  logic [3:0]  res,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic [3:0]  fail_mask,
    output logic        first_vld,
    output logic [3:0]  first_vec,
    output logic [3:0]  first_res,
    output logic [15:0] cover_map,
    output logic        ovr
);

    // Value loaded into the settle counter on capture; the counter then
    // counts down to zero, giving SETTLE cycles in the SETTLE state.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  vec_q;
    logic [3:0]  cnt;

    // ------------------------------------------------------------------
    // Check-cycle datapath
    // ------------------------------------------------------------------
    logic        exp_bit;
    logic [3:0]  miss;
    logic [15:0] vec_onehot;
    logic        all_covered;
    logic        accept;
    logic        check_en;
    logic        drop;

    always_comb begin
        exp_bit     = TRUTH[vec_q];
        miss        = res ^ {4{exp_bit}};
        vec_onehot  = 16'd1 << vec_q;
        // Includes the vector being checked right now, so DONE is entered
        // directly from the check that completes the map.
        all_covered = ((cover_map | vec_onehot) == 16'hFFFF);
        accept      = !clr && vld && (state == S_IDLE);
        check_en    = !clr && (state == S_CHECK);
        drop        = !clr && vld && (state != S_IDLE);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (vld) state_nxt = S_SETTLE;
                S_SETTLE: if (cnt == 4'd0) state_nxt = S_CHECK;
                S_CHECK:  state_nxt = all_covered ? S_DONE : S_IDLE;
                S_DONE:   state_nxt = S_DONE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // busy/done are registered from the next state so they line up with the
    // state register rather than being decoded after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == S_SETTLE) || (state_nxt == S_CHECK);
            done <= (state_nxt == S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Vector capture and settle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= 4'd0;
            cnt   <= 4'd0;
        end else if (clr) begin
            vec_q <= 4'd0;
            cnt   <= 4'd0;
        end else if (accept) begin
            vec_q <= vec;
            cnt   <= SETTLE_LOAD;
        end else if ((state == S_SETTLE) && (cnt != 4'd0)) begin
            cnt   <= cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            err_cnt   <= 8'd0;
            fail_mask <= 4'd0;
            first_vld <= 1'b0;
            first_vec <= 4'd0;
            first_res <= 4'd0;
            cover_map <= 16'd0;
            ovr       <= 1'b0;
        end else if (clr) begin
            err       <= 1'b0;
            err_cnt   <= 8'd0;
            fail_mask <= 4'd0;
            first_vld <= 1'b0;
            first_vec <= 4'd0;
            first_res <= 4'd0;
            cover_map <= 16'd0;
            ovr       <= 1'b0;
        end else begin
            if (drop) begin
                ovr <= 1'b1;
            end
            if (check_en) begin
                fail_mask <= fail_mask | miss;
                cover_map <= cover_map | vec_onehot;
                if (miss != 4'd0) begin
                    err <= 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                    if (!first_vld) begin
                        first_vld <= 1'b1;
                        first_vec <= vec_q;
                        first_res <= res;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
